rf_mp_scoreboard: RTL and testbench
===================================

// Module: rf_mp_scoreboard
// PURPOSE
//  Parametrised multi-port register file with a per-register pending-write scoreboard,
//  intended for the pipelined/superscalar core.
//  N asynchronous read ports and M synchronous write ports, with optional write-to-read bypass.
//  Each read port reports a busy flag so decode can stall on RAW hazards; register 0 is hardwired to zero.
// PARAMETERS
//  XLEN       32  data width of every register
//  NREGS      32  register count, power of 2 >= 2; AW = $clog2(NREGS)
//  NUM_RP      2  number of read ports, >= 1
//  NUM_WP      2  number of write ports, >= 1
//  BYPASS_EN   0  1: same-cycle write data forwarded to read ports and busy suppressed
// PORTS
//  i_clk          in   1            global clock, rising edge
//  i_rst_n        in   1            asynchronous active-low reset
//  i_raddr        in   NUM_RP*AW    read addresses, port j = [j*AW +: AW]
//  o_rdata        out  NUM_RP*XLEN  read data, port j = [j*XLEN +: XLEN]
//  o_rbusy        out  NUM_RP       port j reads a register with a pending write
//  i_wen          in   NUM_WP       write enable per port
//  i_waddr        in   NUM_WP*AW    write addresses
//  i_wdata        in   NUM_WP*XLEN  write data
//  i_issue_valid  in   1            an instruction producing a register issues this cycle
//  i_issue_rd     in   AW           destination register of the issuing instruction
//  o_pending      out  NREGS        scoreboard bit vector, bit r = register r pending
//  o_pending_any  out  1            OR of o_pending
// BEHAVIOUR
//  Reset (async, i_rst_n=0): all registers <= 0 and all pending bits <= 0 immediately, with no clock needed.
//   Consequently every o_rdata=0, o_rbusy=0, o_pending=0, o_pending_any=0 while reset is held.
//   Reset asserted mid-operation discards any in-flight write or issue in that cycle.
//  Write: at posedge, port k with i_wen[k]=1 and waddr!=0 stores wdata. Writes to address 0 are discarded.
//   If multiple ports target the same address in one cycle, the highest-index port wins.
//   Writes to different addresses in the same cycle all commit.
//  Read: combinational, zero latency. raddr=0 -> rdata=0 and rbusy=0 always.
//   BYPASS_EN=0: rdata = stored value. A write in the current cycle becomes visible the next cycle.
//   BYPASS_EN=1: if any enabled write port matches raddr (!=0), rdata = wdata of the highest-index
//   matching port, otherwise the stored value.
//  Scoreboard, per register r != 0, updated at posedge:
//   set   = i_issue_valid && i_issue_rd==r
//   clear = any k: i_wen[k] && i_waddr[k]==r
//   next  = set ? 1 : (clear ? 0 : pending[r])
//   When set and clear coincide, set wins: the issuing instruction is the younger producer.
//   pending[0] is constant 0. Issue to rd=0 is ignored. Re-issue to an already-pending register keeps it at 1.
//   A write to a non-pending register commits data normally and leaves pending at 0.
//  Busy flags:
//   BYPASS_EN=0: o_rbusy[j] = pending[raddr_j].
//   BYPASS_EN=1: o_rbusy[j] = pending[raddr_j] && !(clear of raddr_j this cycle).
//   The forwarded value satisfies the reader. Same-cycle issue does not raise busy until the next cycle.
//  o_pending and o_pending_any are registered state, so they have no combinational path from inputs.
//  Internally there is no other state, and the block has no handshakes: the consumer stalls on o_rbusy.
// TESTING
//  1 Reset: drive writes, then pulse i_rst_n=0 between edges -> all rdata=0 and o_pending=0 before the next edge.
//  2 BYPASS_EN=0: write x5=32'hDEADBEEF on port 0 and read x5 in the same cycle -> old value 0;
//    next cycle -> 32'hDEADBEEF. Write to x0 -> reads 0.
//  3 Dual-write collision: port0 x7=32'h1111 and port1 x7=32'h2222 at the same edge -> x7=32'h2222.
//    With BYPASS_EN=1, same-cycle read of x7 -> 32'h2222.
//  4 Scoreboard: issue rd=3, then read x3 -> rbusy=1 and o_pending[3]=1.
//    Write x3 -> BYPASS_EN=1: rbusy=0 that cycle; BYPASS_EN=0: rbusy=0 next cycle; pending[3]=0 after the edge.
//  5 Set/clear race: with pending[9]=1, issue rd=9 and write x9 at the same edge
//    -> pending[9] stays 1 and x9 is updated.
//  6 Param sweep NREGS=64, XLEN=64, NUM_RP=4, NUM_WP=3: random writes/issues checked against a
//    reference model for 10k cycles with 0 mismatches.

Source files
------------

// File: rtl/rf_mp_scoreboard_if.sv
// Read, write, issue and scoreboard signal bundle for rf_mp_scoreboard.
// The slave modport is the register file side, master is the core side.
interface rf_mp_scoreboard_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NUM_RP = 2,
    parameter int unsigned NUM_WP = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NUM_RP*AW-1:0]   i_raddr;
    logic [NUM_RP*XLEN-1:0] o_rdata;
    logic [NUM_RP-1:0]      o_rbusy;
    logic [NUM_WP-1:0]      i_wen;
    logic [NUM_WP*AW-1:0]   i_waddr;
    logic [NUM_WP*XLEN-1:0] i_wdata;
    logic                   i_issue_valid;
    logic [AW-1:0]          i_issue_rd;
    logic [NREGS-1:0]       o_pending;
    logic                   o_pending_any;

    modport slave (
        input  i_raddr, i_wen, i_waddr, i_wdata, i_issue_valid, i_issue_rd,
        output o_rdata, o_rbusy, o_pending, o_pending_any
    );

    modport master (
        output i_raddr, i_wen, i_waddr, i_wdata, i_issue_valid, i_issue_rd,
        input  o_rdata, o_rbusy, o_pending, o_pending_any
    );
endinterface

// File: rtl/rf_mp_scoreboard.sv
// Multi-port register file (async reads, sync writes, optional bypass) with a
// per-register pending-write scoreboard; x0 reads as zero and is never pending.
module rf_mp_scoreboard #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned NUM_RP    = 2,
    parameter int unsigned NUM_WP    = 2,
    parameter bit          BYPASS_EN = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    rf_mp_scoreboard_if.slave    bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]        r_regs [NREGS];
    logic [NREGS-1:0]       r_pending;

    logic [AW-1:0]          w_waddr [NUM_WP];
    logic [XLEN-1:0]        w_wdata [NUM_WP];
    logic [NUM_WP-1:0]      w_wen;
    logic [NREGS-1:0]       w_set;
    logic [NREGS-1:0]       w_clr;
    logic [NUM_RP*XLEN-1:0] w_rdata;
    logic [NUM_RP-1:0]      w_rbusy;

    // Unpack write ports; a write to x0 is treated as no write at all.
    for (genvar k = 0; k < NUM_WP; k++) begin : g_wp
        assign w_waddr[k] = bus.i_waddr[k*AW +: AW];
        assign w_wdata[k] = bus.i_wdata[k*XLEN +: XLEN];
        assign w_wen[k]   = bus.i_wen[k] && (w_waddr[k] != '0);
    end

    always_comb begin : sb_set_clr
        w_set = '0;
        w_clr = '0;
        if (bus.i_issue_valid) begin
            w_set[bus.i_issue_rd] = 1'b1;
        end
        for (int k = 0; k < NUM_WP; k++) begin
            if (w_wen[k]) begin
                w_clr[w_waddr[k]] = 1'b1;
            end
        end
        w_set[0] = 1'b0;
        w_clr[0] = 1'b0;
    end

    // Later ports overwrite earlier ones, so the highest-index port wins a collision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin : regfile
        if (!i_rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WP; k++) begin
                if (w_wen[k]) begin
                    r_regs[w_waddr[k]] <= w_wdata[k];
                end
            end
        end
    end

    // Set dominates clear: the issuing instruction is the younger producer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin : scoreboard
        if (!i_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    for (genvar j = 0; j < NUM_RP; j++) begin : g_rp
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;
        logic            w_busy;

        assign w_ra = bus.i_raddr[j*AW +: AW];

        always_comb begin : rd_port
            w_rd   = r_regs[w_ra];
            w_busy = r_pending[w_ra];
            if (BYPASS_EN) begin
                for (int k = 0; k < NUM_WP; k++) begin
                    if (w_wen[k] && (w_waddr[k] == w_ra)) begin
                        w_rd = w_wdata[k];
                    end
                end
                if (w_clr[w_ra]) begin
                    w_busy = 1'b0;
                end
            end
            if (w_ra == '0) begin
                w_rd   = '0;
                w_busy = 1'b0;
            end
        end

        assign w_rdata[j*XLEN +: XLEN] = w_rd;
        assign w_rbusy[j]              = w_busy;
    end

    assign bus.o_rdata       = w_rdata;
    assign bus.o_rbusy       = w_rbusy;
    assign bus.o_pending     = r_pending;
    assign bus.o_pending_any = |r_pending;

endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Bench for rf_mp_scoreboard: directed tables on 32x32 instances (bypass off/on)
// and a random run of three configurations against a behavioural model.
module tb_rf_mp_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_mp_scoreboard_if #(.XLEN(32), .NREGS(32), .NUM_RP(2), .NUM_WP(2)) if_a ();
    rf_mp_scoreboard_if #(.XLEN(32), .NREGS(32), .NUM_RP(2), .NUM_WP(2)) if_b ();
    rf_mp_scoreboard_if #(.XLEN(64), .NREGS(64), .NUM_RP(4), .NUM_WP(3)) if_c ();

    rf_mp_scoreboard #(.XLEN(32), .NREGS(32), .NUM_RP(2), .NUM_WP(2), .BYPASS_EN(1'b0))
        dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(if_a));
    rf_mp_scoreboard #(.XLEN(32), .NREGS(32), .NUM_RP(2), .NUM_WP(2), .BYPASS_EN(1'b1))
        dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(if_b));
    rf_mp_scoreboard #(.XLEN(64), .NREGS(64), .NUM_RP(4), .NUM_WP(3), .BYPASS_EN(1'b1))
        dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c));

    int checks = 0;
    int errors = 0;

    // configuration of each instance: 0 = a, 1 = b, 2 = c
    int cfg_nregs [3] = '{32, 32, 64};
    int cfg_nrp   [3] = '{2, 2, 4};
    int cfg_nwp   [3] = '{2, 2, 3};
    bit cfg_byp   [3] = '{1'b0, 1'b1, 1'b1};
    int cfg_xlen  [3] = '{32, 32, 64};

    // current stimulus per instance
    int          ra  [3][4];
    bit          we  [3][3];
    int          wa  [3][3];
    logic [63:0] wd  [3][3];
    bit          iv  [3];
    int          ird [3];

    // reference model state
    logic [63:0] m_regs [3][64];
    bit          m_pend [3][64];

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  busy;
        logic [31:0] pend;
    } vec_t;

    vec_t tbl_a [$];
    vec_t tbl_b [$];

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive_dut(input int d);
        case (d)
            0: begin
                if_a.i_raddr       = {5'(ra[0][1]), 5'(ra[0][0])};
                if_a.i_wen         = {we[0][1], we[0][0]};
                if_a.i_waddr       = {5'(wa[0][1]), 5'(wa[0][0])};
                if_a.i_wdata       = {wd[0][1][31:0], wd[0][0][31:0]};
                if_a.i_issue_valid = iv[0];
                if_a.i_issue_rd    = 5'(ird[0]);
            end
            1: begin
                if_b.i_raddr       = {5'(ra[1][1]), 5'(ra[1][0])};
                if_b.i_wen         = {we[1][1], we[1][0]};
                if_b.i_waddr       = {5'(wa[1][1]), 5'(wa[1][0])};
                if_b.i_wdata       = {wd[1][1][31:0], wd[1][0][31:0]};
                if_b.i_issue_valid = iv[1];
                if_b.i_issue_rd    = 5'(ird[1]);
            end
            default: begin
                if_c.i_raddr       = {6'(ra[2][3]), 6'(ra[2][2]), 6'(ra[2][1]), 6'(ra[2][0])};
                if_c.i_wen         = {we[2][2], we[2][1], we[2][0]};
                if_c.i_waddr       = {6'(wa[2][2]), 6'(wa[2][1]), 6'(wa[2][0])};
                if_c.i_wdata       = {wd[2][2], wd[2][1], wd[2][0]};
                if_c.i_issue_valid = iv[2];
                if_c.i_issue_rd    = 6'(ird[2]);
            end
        endcase
    endtask

    task automatic clear_all();
        for (int d = 0; d < 3; d++) begin
            for (int j = 0; j < 4; j++) ra[d][j] = 0;
            for (int k = 0; k < 3; k++) begin
                we[d][k] = 1'b0;
                wa[d][k] = 0;
                wd[d][k] = '0;
            end
            iv[d]  = 1'b0;
            ird[d] = 0;
            drive_dut(d);
        end
    endtask

    function automatic logic [63:0] get_rd(input int d, input int j);
        case (d)
            0:       return 64'(if_a.o_rdata[j*32 +: 32]);
            1:       return 64'(if_b.o_rdata[j*32 +: 32]);
            default: return if_c.o_rdata[j*64 +: 64];
        endcase
    endfunction

    function automatic logic [63:0] get_busy(input int d, input int j);
        case (d)
            0:       return 64'(if_a.o_rbusy[j]);
            1:       return 64'(if_b.o_rbusy[j]);
            default: return 64'(if_c.o_rbusy[j]);
        endcase
    endfunction

    function automatic logic [63:0] get_pend(input int d);
        case (d)
            0:       return 64'(if_a.o_pending);
            1:       return 64'(if_b.o_pending);
            default: return if_c.o_pending;
        endcase
    endfunction

    function automatic logic [63:0] get_any(input int d);
        case (d)
            0:       return 64'(if_a.o_pending_any);
            1:       return 64'(if_b.o_pending_any);
            default: return 64'(if_c.o_pending_any);
        endcase
    endfunction

    task automatic run_rows(input int d, input string tag, input vec_t q[$]);
        foreach (q[i]) begin
            @(negedge clk);
            clear_all();
            we[d][0] = q[i].wen[0];  wa[d][0] = int'(q[i].wa0);  wd[d][0] = 64'(q[i].wd0);
            we[d][1] = q[i].wen[1];  wa[d][1] = int'(q[i].wa1);  wd[d][1] = 64'(q[i].wd1);
            iv[d] = q[i].iv;         ird[d] = int'(q[i].ird);
            ra[d][0] = int'(q[i].ra0);
            ra[d][1] = int'(q[i].ra1);
            drive_dut(d);
            #1;
            chk({tag, "_rdata0"}, i, get_rd(d, 0), 64'(q[i].rd0));
            chk({tag, "_rdata1"}, i, get_rd(d, 1), 64'(q[i].rd1));
            chk({tag, "_rbusy"}, i, {get_busy(d, 1)[0], get_busy(d, 0)[0]} & 64'h3, 64'(q[i].busy));
            chk({tag, "_pending"}, i, get_pend(d), 64'(q[i].pend));
            chk({tag, "_pending_any"}, i, get_any(d), 64'(q[i].pend != 32'h0));
        end
    endtask

    function automatic int rnd_addr(input int n);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, n - 1));
        return int'($urandom_range(0, 7));
    endfunction

    // Expected read value: x0 is zero; with bypass the last enabled writer to the address wins.
    function automatic logic [63:0] m_rd(input int d, input int j);
        int a;
        logic [63:0] v;
        a = ra[d][j];
        if (a == 0) return '0;
        v = m_regs[d][a];
        if (cfg_byp[d]) begin
            for (int k = 0; k < cfg_nwp[d]; k++)
                if (we[d][k] && wa[d][k] == a) v = wd[d][k];
        end
        return v;
    endfunction

    function automatic logic [63:0] m_busy(input int d, input int j);
        int a;
        bit b;
        a = ra[d][j];
        if (a == 0) return '0;
        b = m_pend[d][a];
        if (cfg_byp[d]) begin
            for (int k = 0; k < cfg_nwp[d]; k++)
                if (we[d][k] && wa[d][k] == a) b = 1'b0;
        end
        return 64'(b);
    endfunction

    function automatic logic [63:0] m_pvec(input int d);
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < cfg_nregs[d]; r++) v[r] = m_pend[d][r];
        return v;
    endfunction

    task automatic m_edge(input int d);
        bit set, clr;
        for (int k = 0; k < cfg_nwp[d]; k++)
            if (we[d][k] && wa[d][k] != 0) m_regs[d][wa[d][k]] = wd[d][k];
        for (int r = 1; r < cfg_nregs[d]; r++) begin
            set = iv[d] && (ird[d] == r);
            clr = 1'b0;
            for (int k = 0; k < cfg_nwp[d]; k++)
                if (we[d][k] && wa[d][k] == r) clr = 1'b1;
            if (set) m_pend[d][r] = 1'b1;
            else if (clr) m_pend[d][r] = 1'b0;
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 3; d++)
            for (int r = 0; r < 64; r++) begin
                m_regs[d][r] = '0;
                m_pend[d][r] = 1'b0;
            end
    endtask

    initial begin
        //             wen   wa0    wd0            wa1    wd1           iv    ird    ra0    ra1    rd0            rd1            busy   pend
        tbl_a.push_back('{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0});
        tbl_a.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0});
        tbl_a.push_back('{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0});
        tbl_a.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0});
        tbl_a.push_back('{2'b11, 5'd7,  32'h1111,     5'd7,  32'h2222,     1'b0, 5'd0,  5'd7,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0});
        tbl_a.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd5,  32'h2222,     32'hDEADBEEF, 2'b00, 32'h0});
        tbl_a.push_back('{2'b11, 5'd1,  32'hA1,       5'd2,  32'hB2,       1'b0, 5'd0,  5'd1,  5'd2,  32'h0,        32'h0,        2'b00, 32'h0});
        tbl_a.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd1,  5'd2,  32'hA1,       32'hB2,       2'b00, 32'h0});
        tbl_a.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd7,  32'h0,        32'h2222,     2'b00, 32'h0});
        tbl_a.push_back('{2'b10, 5'd0,  32'h0,        5'd3,  32'h33,       1'b0, 5'd0,  5'd3,  5'd0,  32'h0,        32'h0,        2'b01, 32'h8});
        tbl_a.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd0,  32'h33,       32'h0,        2'b00, 32'h0});
        tbl_a.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd3,  32'h0,        32'h33,       2'b00, 32'h0});
        tbl_a.push_back('{2'b01, 5'd9,  32'h99,       5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 32'h200});
        tbl_a.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h99,       32'h99,       2'b11, 32'h200});
        tbl_a.push_back('{2'b10, 5'd0,  32'h0,        5'd9,  32'hAA,       1'b0, 5'd0,  5'd9,  5'd0,  32'h99,       32'h0,        2'b01, 32'h200});
        tbl_a.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd0,  5'd9,  5'd0,  32'hAA,       32'h0,        2'b00, 32'h0});
        tbl_a.push_back('{2'b01, 5'd12, 32'h12C,      5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd12, 32'h0,        32'h0,        2'b00, 32'h0});
        tbl_a.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd5,  32'h12C,      32'hDEADBEEF, 2'b00, 32'h0});

        tbl_b.push_back('{2'b11, 5'd7,  32'h1111,     5'd7,  32'h2222,     1'b0, 5'd0,  5'd7,  5'd8,  32'h2222,     32'h0,        2'b00, 32'h0});
        tbl_b.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd0,  32'h2222,     32'h0,        2'b00, 32'h0});
        tbl_b.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd7,  32'h0,        32'h2222,     2'b00, 32'h0});
        tbl_b.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd0,  32'h0,        32'h0,        2'b01, 32'h8});
        tbl_b.push_back('{2'b01, 5'd3,  32'h55,       5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'h55,       32'h55,       2'b00, 32'h8});
        tbl_b.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd7,  32'h55,       32'h2222,     2'b00, 32'h0});
        tbl_b.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0});
        tbl_b.push_back('{2'b10, 5'd0,  32'h0,        5'd9,  32'h99,       1'b1, 5'd9,  5'd9,  5'd9,  32'h99,       32'h99,       2'b00, 32'h200});
        tbl_b.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd0,  32'h99,       32'h0,        2'b01, 32'h200});
        tbl_b.push_back('{2'b01, 5'd0,  32'hBAD,      5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd9,  32'h0,        32'h99,       2'b10, 32'h200});
        tbl_b.push_back('{2'b11, 5'd4,  32'h1,        5'd5,  32'h2,        1'b0, 5'd0,  5'd4,  5'd5,  32'h1,        32'h2,        2'b00, 32'h200});
        tbl_b.push_back('{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd5,  32'h1,        32'h2,        2'b00, 32'h200});

        rst_n = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_rows(0, "a", tbl_a);
        run_rows(1, "b", tbl_b);

        // Reset between edges clears state at once; writes/issues held during reset are dropped.
        @(negedge clk);
        clear_all();
        we[0][0] = 1'b1; wa[0][0] = 20; wd[0][0] = 64'h77; iv[0] = 1'b1; ird[0] = 4;
        drive_dut(0);
        @(negedge clk);
        clear_all();
        ra[0][0] = 20; ra[1][0] = 9;
        drive_dut(0); drive_dut(1);
        #1;
        chk("pre_rst_a_rdata", 0, get_rd(0, 0), 64'h77);
        chk("pre_rst_a_pending", 0, get_pend(0), 64'h10);
        chk("pre_rst_b_rdata", 0, get_rd(1, 0), 64'h99);
        chk("pre_rst_b_rbusy", 0, get_busy(1, 0), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_a_rdata", 0, get_rd(0, 0), 64'h0);
        chk("rst_a_pending", 0, get_pend(0), 64'h0);
        chk("rst_a_pending_any", 0, get_any(0), 64'h0);
        chk("rst_b_rdata", 0, get_rd(1, 0), 64'h0);
        chk("rst_b_rbusy", 0, get_busy(1, 0), 64'h0);
        chk("rst_b_pending", 0, get_pend(1), 64'h0);
        clear_all();
        we[0][0] = 1'b1; wa[0][0] = 21; wd[0][0] = 64'h55; iv[0] = 1'b1; ird[0] = 6;
        drive_dut(0);
        @(negedge clk);
        clear_all();
        ra[0][0] = 21; ra[0][1] = 20;
        drive_dut(0);
        rst_n = 1'b1;
        #1;
        chk("rst_drop_rdata", 0, get_rd(0, 0), 64'h0);
        chk("rst_drop_rdata_old", 0, get_rd(0, 1), 64'h0);
        chk("rst_drop_pending", 0, get_pend(0), 64'h0);

        // Random run of all three instances against the model.
        @(negedge clk);
        clear_all();
        rst_n = 1'b0;
        #1;
        m_reset();
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                for (int j = 0; j < 4; j++) ra[d][j] = rnd_addr(cfg_nregs[d]);
                for (int k = 0; k < 3; k++) begin
                    we[d][k] = ($urandom_range(0, 1) == 1);
                    wa[d][k] = rnd_addr(cfg_nregs[d]);
                    wd[d][k] = {$urandom(), $urandom()};
                    if (cfg_xlen[d] == 32) wd[d][k][63:32] = '0;
                end
                iv[d]  = ($urandom_range(0, 2) != 0);
                ird[d] = rnd_addr(cfg_nregs[d]);
                drive_dut(d);
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                for (int j = 0; j < cfg_nrp[d]; j++) begin
                    chk("rnd_rdata", d * 100 + j, get_rd(d, j), m_rd(d, j));
                    chk("rnd_rbusy", d * 100 + j, get_busy(d, j), m_busy(d, j));
                end
                chk("rnd_pending", d, get_pend(d), m_pvec(d));
                chk("rnd_pending_any", d, get_any(d), 64'(m_pvec(d) != 64'h0));
            end
            for (int d = 0; d < 3; d++) m_edge(d);
        end

        @(negedge clk);
        clear_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
